n_bit_cla_adder: RTL and testbench

Parameterised N-bit carry-lookahead adder computing a + b + c_in into an N-bit sum and a carry-out. The sum path is purely combinational with zero-cycle latency, and a registered copy of the result is provided for pipelined consumers. Used as the generic arithmetic primitive wherever a fast fixed-width add is needed.

---
 rtl/n_bit_cla_adder_pkg.sv | 13 +
 rtl/n_bit_cla_adder_cla_group4.sv | 56 +++++
 rtl/n_bit_cla_adder.sv | 88 ++++++++
 tb/tb_n_bit_cla_adder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/n_bit_cla_adder_pkg.sv
// rtl/n_bit_cla_adder_pkg.sv - shared constants and width helper for the CLA adder
// Purpose: group width of the lookahead blocks and the padded operand width.
// Ports: none (package).
package n_bit_cla_adder_pkg;

    localparam int CLA_GROUP_W = 4;

    // Operand width rounded up to a whole number of lookahead groups.
    function automatic int cla_padded_width(input int numbits);
        return ((numbits + CLA_GROUP_W - 1) / CLA_GROUP_W) * CLA_GROUP_W;
    endfunction

endpackage

// File: rtl/n_bit_cla_adder_cla_group4.sv
// rtl/n_bit_cla_adder_cla_group4.sv - 4-bit carry-lookahead group, purely combinational
// Purpose: sums one 4-bit slice with all internal carries in lookahead form and
//          exports group generate/propagate for the inter-group carry logic.
// Ports:
//   a, b  : 4-bit operand slices
//   cin   : carry into bit 0 of the group
//   s     : 4-bit slice sum
//   grp_g : group generate (carry out independent of cin)
//   grp_p : group propagate (cin passes straight through)
//   cout  : carry out of bit 3
module cla_group4
    import n_bit_cla_adder_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] a,
    input  logic [CLA_GROUP_W-1:0] b,
    input  logic                   cin,
    output logic [CLA_GROUP_W-1:0] s,
    output logic                   grp_g,
    output logic                   grp_p,
    output logic                   cout
);

    logic [CLA_GROUP_W-1:0] g;
    logic [CLA_GROUP_W-1:0] p;
    logic [CLA_GROUP_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products from cin; no carry feeds another.
    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign grp_g = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;

    assign s    = p ^ c[CLA_GROUP_W-1:0];
    assign cout = c[CLA_GROUP_W];

endmodule

// File: rtl/n_bit_cla_adder.sv
// rtl/n_bit_cla_adder.sv - parameterised N-bit carry-lookahead adder with registered copy
// Purpose: {c_out, s} = a + b + c_in combinationally; s_q/c_out_q are the same
//          result delayed by one clk.
// Ports:
//   clk     : clock for the registered result only
//   rst_n   : asynchronous active-low reset of the registered result only
//   a, b    : NUMBITS-wide unsigned operands
//   c_in    : carry-in
//   s       : combinational sum, NUMBITS wide
//   c_out   : combinational carry into bit NUMBITS
//   s_q     : registered s
//   c_out_q : registered c_out
module n_bit_cla_adder
    import n_bit_cla_adder_pkg::*;
#(
    parameter int NUMBITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUMBITS-1:0] a,
    input  logic [NUMBITS-1:0] b,
    input  logic               c_in,
    output logic [NUMBITS-1:0] s,
    output logic               c_out,
    output logic [NUMBITS-1:0] s_q,
    output logic               c_out_q
);

    localparam int PAD_W = cla_padded_width(NUMBITS);
    localparam int NUM_GRP = PAD_W / CLA_GROUP_W;

    logic [PAD_W-1:0]   a_pad;
    logic [PAD_W-1:0]   b_pad;
    logic [PAD_W-1:0]   s_pad;
    logic [NUM_GRP-1:0] grp_g;
    logic [NUM_GRP-1:0] grp_p;
    logic [NUM_GRP-1:0] grp_cout;
    logic [NUM_GRP:0]   grp_c;

    assign a_pad = PAD_W'(a);
    assign b_pad = PAD_W'(b);

    assign grp_c[0] = c_in;

    genvar k;
    generate
        for (k = 0; k < NUM_GRP; k++) begin : g_grp
            cla_group4 u_grp (
                .a     (a_pad[k*CLA_GROUP_W +: CLA_GROUP_W]),
                .b     (b_pad[k*CLA_GROUP_W +: CLA_GROUP_W]),
                .cin   (grp_c[k]),
                .s     (s_pad[k*CLA_GROUP_W +: CLA_GROUP_W]),
                .grp_g (grp_g[k]),
                .grp_p (grp_p[k]),
                .cout  (grp_cout[k])
            );

            // Group-to-group chain on G/P; the group's own cout is the same value.
            assign grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end

        // With zero padding the first padded bit has p=0, so its sum bit is
        // exactly the carry into bit NUMBITS.
        if (PAD_W > NUMBITS) begin : g_cout_padded
            assign c_out = s_pad[NUMBITS];
        end else begin : g_cout_exact
            assign c_out = grp_c[NUM_GRP];
        end
    endgenerate

    assign s = s_pad[NUMBITS-1:0];

    // Padded sum bits, the redundant group couts and (when padded) the top
    // group carry are intentionally dropped.
    logic unused_bits;
    assign unused_bits = &{1'b0, grp_cout, grp_c, s_pad};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
        end else begin
            s_q     <= s;
            c_out_q <= c_out;
        end
    end

endmodule

// File: tb/tb_n_bit_cla_adder.sv
// tb/tb_n_bit_cla_adder.sv - directed self-checking bench for n_bit_cla_adder
module tb_n_bit_cla_adder;

    logic clk;
    logic rst_n;

    logic [3:0] a4, b4, s4, s4_q;
    logic       ci4, co4, co4_q;

    logic [7:0] a8, b8, s8, s8_q;
    logic       ci8, co8, co8_q;

    logic [5:0] a6, b6, s6, s6_q;
    logic       ci6, co6, co6_q;

    int total = 0;
    int bad   = 0;

    n_bit_cla_adder #(.NUMBITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c_in(ci4),
        .s(s4), .c_out(co4), .s_q(s4_q), .c_out_q(co4_q)
    );

    n_bit_cla_adder #(.NUMBITS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c_in(ci8),
        .s(s8), .c_out(co8), .s_q(s8_q), .c_out_q(co8_q)
    );

    n_bit_cla_adder #(.NUMBITS(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .a(a6), .b(b6), .c_in(ci6),
        .s(s6), .c_out(co6), .s_q(s6_q), .c_out_q(co6_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] exp5;
        logic [4:0] prev5;

        rst_n = 1'b1;
        a4 = '0; b4 = '0; ci4 = 1'b0;
        a8 = '0; b8 = '0; ci8 = 1'b0;
        a6 = '0; b6 = '0; ci6 = 1'b0;

        // Reset asserted before the first rising edge: registers clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        check("reset_s_q", 64'(s4_q), 64'd0);
        check("reset_c_out_q", 64'(co4_q), 64'd0);

        // Boundary vectors, 4 bits.
        a4 = 4'd0;  b4 = 4'd0; ci4 = 1'b0; #1 check("b4_0p0p0", 64'({co4, s4}), 64'd0);
        a4 = 4'd15; b4 = 4'd0; ci4 = 1'b1; #1 check("b4_15p0p1", 64'({co4, s4}), 64'd16);
        a4 = 4'd8;  b4 = 4'd8; ci4 = 1'b0; #1 check("b4_8p8p0", 64'({co4, s4}), 64'd16);
        a4 = 4'd7;  b4 = 4'd8; ci4 = 1'b0; #1 check("b4_7p8p0", 64'({co4, s4}), 64'd15);
        a4 = 4'd15; b4 = 4'd15; ci4 = 1'b1; #1 check("b4_15p15p1", 64'({co4, s4}), 64'd31);

        // Wide group carry, 8 bits.
        a8 = 8'd255; b8 = 8'd0;   ci8 = 1'b1; #1 check("b8_255p0p1", 64'({co8, s8}), 64'd256);
        a8 = 8'd128; b8 = 8'd127; ci8 = 1'b0; #1 check("b8_128p127p0", 64'({co8, s8}), 64'd255);
        a8 = 8'd170; b8 = 8'd85;  ci8 = 1'b1; #1 check("b8_170p85p1", 64'({co8, s8}), 64'd256);

        // Non-multiple width, 6 bits.
        a6 = 6'd63; b6 = 6'd1;  ci6 = 1'b0; #1 check("b6_63p1p0", 64'({co6, s6}), 64'd64);
        a6 = 6'd32; b6 = 6'd31; ci6 = 1'b0; #1 check("b6_32p31p0", 64'({co6, s6}), 64'd63);
        a6 = 6'd63; b6 = 6'd63; ci6 = 1'b1; #1 check("b6_63p63p1", 64'({co6, s6}), 64'd127);

        // Registered outputs hold zero throughout reset even across clock edges.
        @(posedge clk); #1;
        check("reset_hold_s_q", 64'(s4_q), 64'd0);

        // Exhaustive 4-bit sweep.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); ci4 = 1'(ic);
                    #3;
                    check("exh4", 64'({co4, s4}), 64'(ia + ib + ic));
                end
            end
        end

        // Release reset between edges, then 9+9+1 = 19 -> s=3, c_out=1.
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'd9; b4 = 4'd9; ci4 = 1'b1;
        #1;
        check("reg_comb_s", 64'(s4), 64'd3);
        check("reg_comb_c_out", 64'(co4), 64'd1);
        check("reg_before_edge_s_q", 64'(s4_q), 64'd0);
        @(posedge clk); #1;
        check("reg_s_q", 64'(s4_q), 64'd3);
        check("reg_c_out_q", 64'(co4_q), 64'd1);

        // Random stream over 20 clocks, one-cycle latency on the registered copy.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a4  = 4'($urandom_range(0, 15));
            b4  = 4'($urandom_range(0, 15));
            ci4 = 1'($urandom_range(0, 1));
            prev5 = 5'(32'(a4) + 32'(b4) + 32'(ci4));
            @(posedge clk); #1;
            check("stream_q", 64'({co4_q, s4_q}), 64'(prev5));
        end

        // Mid-stream asynchronous reset between edges.
        a4 = 4'd14; b4 = 4'd13; ci4 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        exp5 = 5'd28;
        check("mid_reset_s_q", 64'(s4_q), 64'd0);
        check("mid_reset_c_out_q", 64'(co4_q), 64'd0);
        check("mid_reset_comb", 64'({co4, s4}), 64'(exp5));
        @(posedge clk); #1;
        check("mid_reset_hold", 64'({co4_q, s4_q}), 64'd0);

        // Release: first rising edge loads the current result.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_release_q", 64'({co4_q, s4_q}), 64'd28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
